pulse_burst_sched: RTL



---
 rtl/pulse_sched_pkg.sv | 6 +
 rtl/rr_arbiter2.sv | 19 +
 rtl/pulse_burst_sched.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pulse_sched_pkg.sv
// pulse_sched_pkg: shared state encoding and sizing constants for the pulse burst scheduler.
package pulse_sched_pkg;
  localparam int N_REQ = 2;
  localparam int BL_W = 4;
  typedef enum logic [2:0] {IDLE, DELAY, HIGH, LOW, TRIG} state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; the last winner loses the next tie.
module rr_arbiter2
  import pulse_sched_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             id_o
);
  logic last_q;
  assign id_o = &req_i ? ~last_q : req_i[1];
  assign gnt_o = ~|req_i ? '0 : (id_o ? 2'b10 : 2'b01);
  // last_q resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) last_q <= 1'b1;
    else if (en_i && |req_i) last_q <= id_o;
endmodule

// File: rtl/pulse_burst_sched.sv
// pulse_burst_sched: arbitrated delay / pulse-burst / trigger-hold sequencer.
// Define SCHED_ABORT_EN to add the abort input and aborted strobe.
module pulse_burst_sched
  import pulse_sched_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DELAY_CYC = 5,
  parameter int HIGH_CYC = 1,
  parameter int LOW_CYC = 1,
  parameter int HOLD_CYC = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic [BL_W-1:0]  burst_len0,
  input  logic [BL_W-1:0]  burst_len1,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             signal,
  output logic             trig,
  output logic             done,
  output logic             done_id
`ifdef SCHED_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);
  localparam logic [CNT_W-1:0] D1 = CNT_W'(DELAY_CYC > 0 ? DELAY_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] H1 = CNT_W'(HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] L1 = CNT_W'(LOW_CYC - 1);
  localparam logic [CNT_W-1:0] T1 = CNT_W'(HOLD_CYC - 1);
  localparam bit HAS_DELAY = DELAY_CYC > 0;
  state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BL_W-1:0] pulse_left_q, len_d;
  logic [N_REQ-1:0] gnt_q, arb_gnt;
  logic busy_q, signal_q, trig_q, done_q, done_id_q, owner_q, arb_id;
  logic more_d;
  rr_arbiter2 u_arb (
    .clock  (clock),
    .reset_n(reset_n),
    .en_i   (state_q == IDLE),
    .req_i  (req),
    .gnt_o  (arb_gnt),
    .id_o   (arb_id)
  );
  assign len_d = arb_id ? burst_len1 : burst_len0;
  // In DELAY, "more" means any pulse at all; in LOW it means one beyond the pulse just finished
  assign more_d = state_q == LOW ? pulse_left_q != BL_W'(1) : pulse_left_q != '0;
`ifdef SCHED_ABORT_EN
  logic aborted_q;
  assign aborted = aborted_q;
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pulse_left_q <= '0;
      gnt_q <= '0;
      busy_q <= 1'b0;
      signal_q <= 1'b0;
      trig_q <= 1'b0;
      done_q <= 1'b0;
      done_id_q <= 1'b0;
      owner_q <= 1'b0;
`ifdef SCHED_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      done_id_q <= 1'b0;
`ifdef SCHED_ABORT_EN
      aborted_q <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q <= IDLE;
        gnt_q <= '0;
        busy_q <= 1'b0;
        signal_q <= 1'b0;
        trig_q <= 1'b0;
        done_q <= 1'b1;
        done_id_q <= owner_q;
        aborted_q <= 1'b1;
      end else
`endif
      case (state_q)
        IDLE:
          if (|req) begin
            gnt_q <= arb_gnt;
            busy_q <= 1'b1;
            owner_q <= arb_id;
            pulse_left_q <= len_d;
            state_q <= HAS_DELAY ? DELAY : (len_d != '0 ? HIGH : TRIG);
            cnt_q <= HAS_DELAY ? D1 : (len_d != '0 ? H1 : T1);
            signal_q <= !HAS_DELAY && len_d != '0;
            trig_q <= !HAS_DELAY && len_d == '0;
          end
        DELAY:
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else begin
            state_q <= more_d ? HIGH : TRIG;
            cnt_q <= more_d ? H1 : T1;
            signal_q <= more_d;
            trig_q <= !more_d;
          end
        HIGH:
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else begin
            state_q <= LOW;
            cnt_q <= L1;
            signal_q <= 1'b0;
          end
        LOW:
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else begin
            pulse_left_q <= pulse_left_q - BL_W'(1);
            state_q <= more_d ? HIGH : TRIG;
            cnt_q <= more_d ? H1 : T1;
            signal_q <= more_d;
            trig_q <= !more_d;
          end
        TRIG:
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else begin
            state_q <= IDLE;
            gnt_q <= '0;
            busy_q <= 1'b0;
            trig_q <= 1'b0;
            done_q <= 1'b1;
            done_id_q <= owner_q;
          end
        default: state_q <= IDLE;
      endcase
    end
  assign gnt = gnt_q;
  assign busy = busy_q;
  assign signal = signal_q;
  assign trig = trig_q;
  assign done = done_q;
  assign done_id = done_id_q;
endmodule
